// File: rtl/alu_issue_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ucpu_pkg
// Shared definitions for the micro-CPU ALU issue path:
//   - datapath / address widths
//   - control_state codes driven to the ALU wrapper
//   - reg_src codes that steer operand loads into ALU A / B
//   - ALU opcode enumeration
//   - packed 16-bit instruction layout
//   - issue sequencer state enumeration
// ---------------------------------------------------------------------------
package ucpu_pkg;

    localparam int ALU_WIDTH      = 8;
    localparam int ALU_OPS        = 16;
    localparam int OP_W           = $clog2(ALU_OPS);
    localparam int NUM_REGS       = 16;
    localparam int REG_AW         = $clog2(NUM_REGS);
    localparam int REG_SRC_W      = 5;
    localparam int CONTROL_STATES = 3;
    localparam int CS_W           = $clog2(CONTROL_STATES);
    localparam int INSTR_W        = 16;

    localparam logic [REG_SRC_W-1:0] A_REG_MAP = 5'd16;
    localparam logic [REG_SRC_W-1:0] B_REG_MAP = 5'd17;

    localparam logic [CS_W-1:0] DECODE   = 2'd0;
    localparam logic [CS_W-1:0] EXECUTE1 = 2'd1;
    localparam logic [CS_W-1:0] EXECUTE2 = 2'd2;

    typedef enum logic [OP_W-1:0] {
        OP_NOP = 4'd0,
        OP_ADD = 4'd1,
        OP_SUB = 4'd2,
        OP_AND = 4'd3,
        OP_OR  = 4'd4,
        OP_NOT = 4'd5,
        OP_XOR = 4'd6,
        OP_SHL = 4'd7,
        OP_SHR = 4'd8,
        OP_CMP = 4'd9
    } alu_op_e;

    // op is kept as raw bits: codes 10..15 are legal (no-op) encodings
    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
    } instr_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4
    } seq_state_e;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// ---------------------------------------------------------------------------
// alu_issue_if
// Bundle between the issue sequencer (master) and the ALU wrapper (slave).
//   control_state : DECODE / EXECUTE1 / EXECUTE2
//   alu_en        : ALU enable
//   alu_op        : opcode presented to the ALU
//   reg_src       : operand-load select (A_REG_MAP / B_REG_MAP / 0)
//   A_bus, B_bus  : operand buses
//   alu_result    : registered ALU result (from ALU)
//   cc_greater    : registered "A > B" flag (from ALU)
//   cc_equal      : registered "A == B" flag (from ALU)
// ---------------------------------------------------------------------------
interface alu_issue_if;
    import ucpu_pkg::*;

    logic [CS_W-1:0]      control_state;
    logic                 alu_en;
    logic [OP_W-1:0]      alu_op;
    logic [REG_SRC_W-1:0] reg_src;
    logic [ALU_WIDTH-1:0] A_bus;
    logic [ALU_WIDTH-1:0] B_bus;
    logic [ALU_WIDTH-1:0] alu_result;
    logic                 cc_greater;
    logic                 cc_equal;

    modport master (
        output control_state, alu_en, alu_op, reg_src, A_bus, B_bus,
        input  alu_result, cc_greater, cc_equal
    );

    modport slave (
        input  control_state, alu_en, alu_op, reg_src, A_bus, B_bus,
        output alu_result, cc_greater, cc_equal
    );

endinterface

// File: rtl/alu_issue_ctrl_decode.sv
// ---------------------------------------------------------------------------
// alu_instr_decode
// Combinational opcode classifier, also reused by the hazard checker.
//   i_op         : 4-bit ALU opcode
//   o_writes_rd  : opcode produces a register-file write (ADD..SHR)
//   o_is_cmp     : opcode updates architectural flags (CMP)
// ---------------------------------------------------------------------------
module alu_instr_decode
    import ucpu_pkg::*;
(
    input  logic [OP_W-1:0] i_op,
    output logic            o_writes_rd,
    output logic            o_is_cmp
);

    always_comb begin
        o_writes_rd = (i_op >= OP_ADD) && (i_op <= OP_SHR);
        o_is_cmp    = (i_op == OP_CMP);
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
// Issue sequencer for the ALU: accepts one instruction per handshake, loads
// operand A, loads operand B, executes, then writes back / updates flags.
//   sysclk        : clock, all state on rising edge
//   rst_n         : asynchronous active-low reset
//   instr_valid   : instruction offered
//   instr_ready   : sequencer can accept (IDLE or WB)
//   instr         : {op, rd, rs1, rs2}
//   rf_raddr      : register file read address (combinational read)
//   rf_rdata      : register file read data
//   alu           : ALU interface (master side)
//   rf_we         : write-back strobe
//   rf_waddr      : write-back address
//   rf_wdata      : write-back data
//   flag_greater  : architectural greater flag
//   flag_equal    : architectural equal flag
//   busy          : instruction in flight
// ---------------------------------------------------------------------------
module alu_issue_ctrl
    import ucpu_pkg::*;
(
    input  logic                 sysclk,
    input  logic                 rst_n,

    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [INSTR_W-1:0]   instr,

    output logic [REG_AW-1:0]    rf_raddr,
    input  logic [ALU_WIDTH-1:0] rf_rdata,

    alu_issue_if.master          alu,

    output logic                 rf_we,
    output logic [REG_AW-1:0]    rf_waddr,
    output logic [ALU_WIDTH-1:0] rf_wdata,

    output logic                 flag_greater,
    output logic                 flag_equal,
    output logic                 busy
);

    seq_state_e r_state;
    instr_t     r_instr;
    logic       r_flag_greater;
    logic       r_flag_equal;

    logic       w_writes_rd;
    logic       w_is_cmp;
    logic       w_accept_slot;

    alu_instr_decode u_decode (
        .i_op        (r_instr.op),
        .o_writes_rd (w_writes_rd),
        .o_is_cmp    (w_is_cmp)
    );

    // IDLE and WB are the only states that can take a new instruction;
    // gating with rst_n keeps instr_ready low while reset is held.
    assign w_accept_slot = rst_n && ((r_state == S_IDLE) || (r_state == S_WB));

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_instr        <= '0;
            r_flag_greater <= 1'b0;
            r_flag_equal   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (instr_valid) begin
                        r_instr <= instr_t'(instr);
                        r_state <= S_LOAD_A;
                    end
                end
                S_LOAD_A: r_state <= S_LOAD_B;
                S_LOAD_B: r_state <= S_EXEC;
                S_EXEC:   r_state <= S_WB;
                S_WB: begin
                    // ALU flags are valid here: they were registered at the end of EXEC
                    if (w_is_cmp) begin
                        r_flag_greater <= alu.cc_greater;
                        r_flag_equal   <= alu.cc_equal;
                    end
                    // Back-to-back accept skips IDLE to keep a 4-cycle cadence
                    if (instr_valid) begin
                        r_instr <= instr_t'(instr);
                        r_state <= S_LOAD_A;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Output decode from state and latched instruction
    always_comb begin
        alu.control_state = DECODE;
        alu.alu_en        = 1'b0;
        alu.alu_op        = '0;
        alu.reg_src       = '0;
        alu.A_bus         = '0;
        alu.B_bus         = '0;
        rf_raddr          = '0;
        rf_we             = 1'b0;
        rf_waddr          = '0;
        rf_wdata          = '0;

        case (r_state)
            S_LOAD_A: begin
                alu.control_state = EXECUTE1;
                alu.alu_en        = 1'b1;
                alu.alu_op        = r_instr.op;
                alu.reg_src       = A_REG_MAP;
                rf_raddr          = r_instr.rs1;
                alu.A_bus         = rf_rdata;
            end
            S_LOAD_B: begin
                alu.control_state = EXECUTE1;
                alu.alu_en        = 1'b1;
                alu.alu_op        = r_instr.op;
                alu.reg_src       = B_REG_MAP;
                rf_raddr          = r_instr.rs2;
                alu.B_bus         = rf_rdata;
            end
            S_EXEC: begin
                alu.control_state = EXECUTE2;
                alu.alu_en        = 1'b1;
                alu.alu_op        = r_instr.op;
            end
            S_WB: begin
                alu.alu_op = r_instr.op;
                if (w_writes_rd) begin
                    rf_we    = 1'b1;
                    rf_waddr = r_instr.rd;
                    rf_wdata = alu.alu_result;
                end
            end
            default: ;
        endcase
    end

    assign instr_ready  = w_accept_slot;
    assign busy         = (r_state != S_IDLE);
    assign flag_greater = r_flag_greater;
    assign flag_equal   = r_flag_equal;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;
    import ucpu_pkg::*;

    logic        sysclk;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [3:0]  rf_raddr;
    logic [7:0]  rf_rdata;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [7:0]  rf_wdata;
    logic        flag_greater;
    logic        flag_equal;
    logic        busy;

    int total = 0;
    int bad   = 0;

    alu_issue_if alu_if ();

    alu_issue_ctrl dut (
        .sysclk       (sysclk),
        .rst_n        (rst_n),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr        (instr),
        .rf_raddr     (rf_raddr),
        .rf_rdata     (rf_rdata),
        .alu          (alu_if),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .flag_greater (flag_greater),
        .flag_equal   (flag_equal),
        .busy         (busy)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    // Register file model: combinational read, write on rising edge.
    // pre_* lets the bench preload values through the same write port.
    logic [7:0] regs [16];
    logic       pre_we;
    logic [3:0] pre_addr;
    logic [7:0] pre_data;

    assign rf_rdata = regs[rf_raddr];

    always @(posedge sysclk) begin
        if (pre_we)
            regs[pre_addr] <= pre_data;
        else if (rf_we)
            regs[rf_waddr] <= rf_wdata;
    end

    // ALU wrapper stub: operand registers, registered result and flags
    logic [7:0] a_r, b_r;

    always @(posedge sysclk) begin
        if (alu_if.alu_en && alu_if.control_state == EXECUTE1) begin
            if (alu_if.reg_src == A_REG_MAP) a_r <= alu_if.A_bus;
            if (alu_if.reg_src == B_REG_MAP) b_r <= alu_if.B_bus;
        end
        if (alu_if.alu_en && alu_if.control_state == EXECUTE2) begin
            case (alu_if.alu_op)
                4'd1: alu_if.alu_result <= a_r + b_r;
                4'd2: alu_if.alu_result <= a_r - b_r;
                4'd3: alu_if.alu_result <= a_r & b_r;
                4'd4: alu_if.alu_result <= a_r | b_r;
                4'd5: alu_if.alu_result <= ~a_r;
                4'd6: alu_if.alu_result <= a_r ^ b_r;
                4'd7: alu_if.alu_result <= a_r << 1;
                4'd8: alu_if.alu_result <= a_r >> 1;
                4'd9: begin
                    alu_if.cc_greater <= (a_r > b_r);
                    alu_if.cc_equal   <= (a_r == b_r);
                end
                default: alu_if.alu_result <= 8'h00;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    task automatic setreg(input logic [3:0] a, input logic [7:0] d);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        step();
        pre_we   = 1'b0;
    endtask

    // Present an instruction for exactly one edge; returns in LOAD_A
    task automatic issue(input logic [15:0] ins);
        instr       = ins;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = 16'h0000;
        pre_we      = 1'b0;
        pre_addr    = 4'h0;
        pre_data    = 8'h00;

        setreg(4'd1, 8'h05);
        setreg(4'd2, 8'h03);
        setreg(4'd3, 8'hAA);
        setreg(4'd4, 8'h0F);
        setreg(4'd5, 8'hF0);
        setreg(4'd8, 8'h09);
        setreg(4'd9, 8'h04);
        setreg(4'd10, 8'h55);
        setreg(4'd11, 8'h07);
        setreg(4'd13, 8'h33);
        setreg(4'd14, 8'h00);
        setreg(4'd15, 8'h77);

        // Reset state
        chk("rst_ready", instr_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cs", alu_if.control_state, 0);
        chk("rst_flags", {flag_greater, flag_equal}, 0);
        rst_n = 1'b1;
        #1;
        chk("idle_ready", instr_ready, 1);
        chk("idle_en", alu_if.alu_en, 0);

        // add R3 = R1 + R2
        issue(16'h1312);
        chk("t1_la_src", alu_if.reg_src, 16);
        chk("t1_la_abus", alu_if.A_bus, 8'h05);
        chk("t1_la_bbus", alu_if.B_bus, 0);
        chk("t1_la_raddr", rf_raddr, 1);
        chk("t1_la_cs", alu_if.control_state, 1);
        chk("t1_la_busy_rdy", {busy, instr_ready}, 2'b10);
        step();
        chk("t1_lb_src", alu_if.reg_src, 17);
        chk("t1_lb_bbus", alu_if.B_bus, 8'h03);
        chk("t1_lb_abus", alu_if.A_bus, 0);
        chk("t1_lb_raddr", rf_raddr, 2);
        step();
        chk("t1_ex_cs", alu_if.control_state, 2);
        chk("t1_ex_op_en", {alu_if.alu_op, alu_if.alu_en}, {4'd1, 1'b1});
        chk("t1_ex_we", rf_we, 0);
        step();
        chk("t1_wb_we", rf_we, 1);
        chk("t1_wb_waddr", rf_waddr, 3);
        chk("t1_wb_wdata", rf_wdata, 8'h08);
        chk("t1_wb_cs_en", {alu_if.control_state, alu_if.alu_en}, 0);
        chk("t1_wb_ready", instr_ready, 1);
        step();
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_op", alu_if.alu_op, 0);
        chk("t1_r3", regs[3], 8'h08);

        // Back-to-back: sub R6 = R1 - R2, then or R7 = R4 | R5
        instr       = 16'h2612;
        instr_valid = 1'b1;
        step();
        instr = 16'h4745;
        step();
        step();
        chk("t2_ex1_we", rf_we, 0);
        step();
        chk("t2_wb1_we", rf_we, 1);
        chk("t2_wb1_waddr", rf_waddr, 6);
        chk("t2_wb1_wdata", rf_wdata, 8'h02);
        chk("t2_wb1_ready", instr_ready, 1);
        step();
        instr_valid = 1'b0;
        chk("t2_la2_busy", busy, 1);
        chk("t2_la2_src", alu_if.reg_src, 16);
        chk("t2_la2_abus", alu_if.A_bus, 8'h0F);
        chk("t2_la2_we", rf_we, 0);
        step();
        chk("t2_lb2_bbus", alu_if.B_bus, 8'hF0);
        step();
        chk("t2_ex2_we", rf_we, 0);
        step();
        chk("t2_wb2_we", rf_we, 1);
        chk("t2_wb2_waddr", rf_waddr, 7);
        chk("t2_wb2_wdata", rf_wdata, 8'hFF);
        step();
        chk("t2_r6", regs[6], 8'h02);
        chk("t2_r7", regs[7], 8'hFF);
        chk("t2_idle_busy", busy, 0);

        // cmp R8(9) vs R9(4)
        issue(16'h9A89);
        step();
        step();
        step();
        chk("t3_wb_we", rf_we, 0);
        step();
        chk("t3_flags_gt", {flag_greater, flag_equal}, 2'b10);
        chk("t3_r10", regs[10], 8'h55);

        // cmp R11 vs R11 (7 == 7)
        issue(16'h9ABB);
        step();
        step();
        step();
        chk("t3b_wb_we", rf_we, 0);
        step();
        chk("t3b_flags_eq", {flag_greater, flag_equal}, 2'b01);

        // op 0: full sequence, no write, flags unchanged
        issue(16'h0A12);
        chk("t4_nop_src", alu_if.reg_src, 16);
        step();
        chk("t4_nop_lb", alu_if.reg_src, 17);
        step();
        chk("t4_nop_cs", alu_if.control_state, 2);
        step();
        chk("t4_nop_we", rf_we, 0);
        chk("t4_nop_busy", busy, 1);
        step();
        chk("t4_nop_flags", {flag_greater, flag_equal}, 2'b01);

        // op 12: same
        issue(16'hCA12);
        step();
        step();
        chk("t4_c_op", alu_if.alu_op, 4'hC);
        step();
        chk("t4_c_we", rf_we, 0);
        step();
        chk("t4_c_flags", {flag_greater, flag_equal}, 2'b01);
        chk("t4_r10", regs[10], 8'h55);

        // Reset during EXEC
        issue(16'h1D12);
        step();
        step();
        chk("t5_ex_cs", alu_if.control_state, 2);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_ready", instr_ready, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_ctl", {alu_if.control_state, alu_if.alu_en, alu_if.alu_op, alu_if.reg_src}, 0);
        chk("t5_rst_bus", {alu_if.A_bus, alu_if.B_bus, rf_raddr}, 0);
        chk("t5_rst_wb", {rf_we, rf_waddr, rf_wdata}, 0);
        chk("t5_rst_flags", {flag_greater, flag_equal}, 0);
        step();
        step();
        chk("t5_rst_we2", rf_we, 0);
        chk("t5_r13", regs[13], 8'h33);
        rst_n = 1'b1;
        #1;
        chk("t5_rel_ready", instr_ready, 1);
        issue(16'h1D12);
        step();
        step();
        step();
        chk("t5_wb_we", rf_we, 1);
        chk("t5_wb_waddr", rf_waddr, 4'hD);
        chk("t5_wb_wdata", rf_wdata, 8'h08);
        step();
        chk("t5_r13_new", regs[13], 8'h08);

        // instr changes during LOAD_B are ignored
        issue(16'h1E12);
        step();
        instr = 16'h2F45;
        step();
        chk("t6_ex_op", alu_if.alu_op, 4'd1);
        step();
        chk("t6_wb_waddr", rf_waddr, 4'hE);
        chk("t6_wb_wdata", rf_wdata, 8'h08);
        step();
        chk("t6_r14", regs[14], 8'h08);
        chk("t6_r15", regs[15], 8'h77);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
